lsu_exec: RTL and testbench
===========================

LSU_EXEC -- requirements
Module: lsu_exec

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 in_valid  input  1  decoded LSU op present.
REQ-004 in_ready  output  1  op accepted when in_valid && in_ready.
REQ-005 is_load, zero_ext, is_nop  input  1 each  decoded control.
REQ-006 size  input  2  0=byte, 1=half, 2 or 3=word.
REQ-007 rd  input  5  load destination register.
REQ-008 imm  input  12  signed offset.
REQ-009 rs1_val, rs2_val  input  32 each  base address, store data.
REQ-010 mem_req  output  1  memory request valid.
REQ-011 mem_we  output  1  1=store, 0=load.
REQ-012 mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-013 mem_wdata  output  32  lane-replicated store data.
REQ-014 mem_be  output  4  byte enables.
REQ-015 mem_gnt  input  1  request accepted this cycle.
REQ-016 mem_rvalid, mem_rdata  input  1, 32  load response.
REQ-017 wb_valid, wb_rd, wb_data  output  1, 5, 32  load writeback.
REQ-018 misalign  output  1  one-cycle pulse: misaligned op dropped.

Function
REQ-019 States IDLE, REQ, WAIT; in_ready SHALL be 1 exactly when state is IDLE.
REQ-020 On accept, block SHALL register addr = rs1_val + sign-extended imm, modulo 2^32, plus is_load, zero_ext, size, rd, rs2_val.
REQ-021 Accepted is_nop SHALL produce no memory request, no writeback, and remain in IDLE.
REQ-022 Misaligned op (half with addr[0]=1; word with addr[1:0]!=0) SHALL issue no request, pulse misalign the following cycle, remain in IDLE.
REQ-023 Aligned op SHALL move IDLE->REQ; mem_req SHALL assert the cycle after accept.
REQ-024 In REQ, mem_req, mem_we, mem_addr, mem_wdata, mem_be SHALL hold stable until the cycle mem_gnt=1.
REQ-025 Store on gnt SHALL go REQ->IDLE; stores produce no response or writeback.
REQ-026 Load on gnt SHALL go REQ->WAIT; mem_req deasserts next cycle.
REQ-027 mem_rvalid SHALL be ignored in IDLE and REQ; memory guarantees rvalid no earlier than the cycle after gnt.
REQ-028 In WAIT with mem_rvalid=1, block SHALL register wb_data/wb_rd, pulse wb_valid for one cycle next cycle, and go WAIT->IDLE.
REQ-029 wb_valid SHALL be suppressed when rd=0 (transaction still completes).
REQ-030 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-031 mem_wdata: byte {4{rs2_val[7:0]}}; half {2{rs2_val[15:0]}}; word rs2_val.
REQ-032 Load extraction: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]; sign-extended unless zero_ext=1; word unmodified.
REQ-033 Minimum load latency: accept cycle 0, req cycle 1, gnt cycle 1, rvalid cycle 2, wb_valid cycle 3.
REQ-034 mem_req, wb_valid, misalign SHALL all be 0 in IDLE except as stated above.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE and clear mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_valid, wb_rd, wb_data, misalign to 0; in_ready=1.
REQ-036 Reset mid-transaction SHALL abandon it; a late mem_rvalid after reset SHALL be ignored.

Verification
REQ-037 LB rs1=0x100, imm=0xFFF, rdata=0x80_00_00_00 at addr 0xFF -> mem_addr 0xFC, mem_be 0b1000, wb_data 0xFFFFFF80.
REQ-038 SH rs1=0x200, imm=2, rs2=0x1234ABCD, gnt delayed 3 cycles -> mem_be 0b1100, mem_wdata 0xABCDABCD held stable 4 cycles, no wb_valid.
REQ-039 LW rs1=0x103, imm=0 -> misalign pulse 1 cycle, mem_req stays 0, in_ready stays 1.
REQ-040 LHU rs1=0x10, imm=2, rdata=0xF00D1234, gnt cycle 1, rvalid cycle 2 -> wb_valid cycle 3, wb_data 0x0000F00D.
REQ-041 LW accepted, reset asserted in WAIT, rvalid arrives after reset release -> wb_valid stays 0, in_ready=1.
REQ-042 is_nop accepted back-to-back with LW rd=0 -> no extra request for nop, LW completes, wb_valid never asserts.

Source files
------------

// File: rtl/lsu_exec.sv
// lsu_exec: single-outstanding load/store execution stage.
// Takes one decoded LSU op at a time, computes the effective address, and
// either drops it (nop / misaligned) or issues one memory request. For loads
// it waits for the response and produces a one-cycle writeback pulse.
//
// Handshake: an op is accepted on a rising edge where in_valid && in_ready.
// in_ready is 1 only in IDLE. A memory request is held stable (valid plus
// payload) from the first REQ cycle until the edge where mem_gnt=1. mem_rvalid
// is only meaningful in WAIT and is ignored in every other state.
module lsu_exec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_load,
    input  logic        zero_ext,
    input  logic        is_nop,
    input  logic [1:0]  size,
    input  logic [4:0]  rd,
    input  logic [11:0] imm,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic        is_load_q;
    logic        zero_ext_q;
    logic [1:0]  size_q;
    logic [4:0]  rd_q;
    logic [31:0] rs2_q;

    logic        accept;
    logic [31:0] eff_addr;
    logic        misal_in;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] load_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign state_dbg = state;
    assign in_ready  = (state == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign eff_addr  = rs1_val + {{20{imm[11]}}, imm};

    // Alignment of the incoming op; size 2 and 3 are both word accesses.
    always_comb begin
        misal_in = 1'b0;
        if (size == 2'd1)
            misal_in = eff_addr[0];
        else if (size[1])
            misal_in = (eff_addr[1:0] != 2'b00);
    end

    // Byte enables, lane-replicated store data and load extraction from the
    // registered op; payload outputs are forced to zero outside REQ.
    always_comb begin
        be_c     = 4'b1111;
        wdata_c  = rs2_q;
        byte_sel = mem_rdata[8*addr_q[1:0] +: 8];
        half_sel = mem_rdata[16*addr_q[1] +: 16];
        load_c   = mem_rdata;
        case (size_q)
            2'd0: begin
                be_c    = 4'b0001 << addr_q[1:0];
                wdata_c = {4{rs2_q[7:0]}};
                load_c  = zero_ext_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'd1: begin
                be_c    = 4'b0011 << {addr_q[1], 1'b0};
                wdata_c = {2{rs2_q[15:0]}};
                load_c  = zero_ext_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = rs2_q;
                load_c  = mem_rdata;
            end
        endcase
    end

    assign mem_req   = (state == S_REQ);
    assign mem_we    = mem_req && !is_load_q;
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'b0;
    assign mem_wdata = mem_req ? wdata_c : 32'b0;
    assign mem_be    = mem_req ? be_c : 4'b0;

    // Control FSM, captured op fields, writeback and misalign pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= 32'b0;
            is_load_q  <= 1'b0;
            zero_ext_q <= 1'b0;
            size_q     <= 2'b0;
            rd_q       <= 5'b0;
            rs2_q      <= 32'b0;
            wb_valid   <= 1'b0;
            wb_rd      <= 5'b0;
            wb_data    <= 32'b0;
            misalign   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && !is_nop) begin
                        if (misal_in) begin
                            misalign <= 1'b1;
                        end else begin
                            state      <= S_REQ;
                            addr_q     <= eff_addr;
                            is_load_q  <= is_load;
                            zero_ext_q <= zero_ext;
                            size_q     <= size;
                            rd_q       <= rd;
                            rs2_q      <= rs2_val;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt)
                        state <= is_load_q ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        state    <= S_IDLE;
                        wb_valid <= (rd_q != 5'd0);
                        wb_rd    <= rd_q;
                        wb_data  <= load_c;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_exec.sv
// tb_lsu_exec: directed and random load/store traffic against lsu_exec with
// a small memory responder and a writeback scoreboard.
module tb_lsu_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_load = 1'b0;
    logic        zero_ext = 1'b0;
    logic        is_nop = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [4:0]  rd = 5'd0;
    logic [11:0] imm = 12'd0;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] rs2_val = 32'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // expected writebacks: {rd, data}
    logic [36:0] exp_q[$];

    lsu_exec dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .is_load(is_load), .zero_ext(zero_ext), .is_nop(is_nop), .size(size),
        .rd(rd), .imm(imm), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign),
        .state_dbg(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'b0001 << a[1:0];
        if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 2'd1) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] f_load(input logic [1:0] sz, input logic zx,
                                           input logic [31:0] a, input logic [31:0] r);
        logic [31:0] sh;
        sh = r >> (8 * a[1:0]);
        if (sz == 2'd0) return (zx || !sh[7]) ? (sh & 32'hFF) : (sh | 32'hFFFF_FF00);
        if (sz == 2'd1) return (zx || !sh[15]) ? (sh & 32'hFFFF) : (sh | 32'hFFFF_0000);
        return r;
    endfunction

    // scoreboard: every writeback pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 64'(wb_valid), 64'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wb_rd", 64'(wb_rd), 64'(e[36:32]));
                check("wb_data", 64'(wb_data), 64'(e[31:0]));
            end
        end
    end

    // driver: present one op for a single cycle, from a negedge to the next
    task automatic send_op(input logic ld, input logic zx, input logic nop,
                           input logic [1:0] sz, input logic [4:0] r,
                           input logic [11:0] im, input logic [31:0] a, input logic [31:0] d);
        check("in_ready_pre", 64'(in_ready), 64'd1);
        in_valid = 1'b1; is_load = ld; zero_ext = zx; is_nop = nop; size = sz;
        rd = r; imm = im; rs1_val = a; rs2_val = d;
        @(negedge clk);
        in_valid = 1'b0; is_nop = 1'b0;
    endtask

    // memory responder: grant after dly extra cycles, respond after rdly WAIT cycles
    task automatic serve(input logic ld, input int dly, input int rdly,
                         input logic [31:0] ea, input logic [3:0] eb,
                         input logic [31:0] ew, input logic [31:0] rdata);
        for (int k = 0; k <= dly; k++) begin
            check("mem_req", 64'(mem_req), 64'd1);
            check("mem_we", 64'(mem_we), 64'(!ld));
            check("mem_addr", 64'(mem_addr), 64'(ea));
            check("mem_be", 64'(mem_be), 64'(eb));
            if (!ld) check("mem_wdata", 64'(mem_wdata), 64'(ew));
            check("in_ready_busy", 64'(in_ready), 64'd0);
            check("misalign_quiet", 64'(misalign), 64'd0);
            if (k == dly) mem_gnt = 1'b1;
            // rvalid while in REQ must be ignored
            mem_rvalid = (k != dly) && ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (ld) begin
            for (int k = 0; k < rdly; k++) begin
                check("req_drop", 64'(mem_req), 64'd0);
                check("in_ready_wait", 64'(in_ready), 64'd0);
                @(negedge clk);
            end
            check("req_drop", 64'(mem_req), 64'd0);
            mem_rvalid = 1'b1; mem_rdata = rdata;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        check("in_ready_done", 64'(in_ready), 64'd1);
        check("mem_req_done", 64'(mem_req), 64'd0);
    endtask

    initial begin
        // reset
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_state", 64'(state_dbg), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_be", 64'(mem_be), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LB with negative offset, top byte lane, sign extension
        send_op(1'b1, 1'b0, 1'b0, 2'd0, 5'd7, 12'hFFF, 32'h100, 32'h0);
        exp_q.push_back({5'd7, 32'hFFFF_FF80});
        serve(1'b1, 0, 0, 32'hFC, 4'b1000, 32'h0, 32'h8000_0000);

        // SH, grant delayed 3 cycles, payload held for 4 cycles
        send_op(1'b0, 1'b0, 1'b0, 2'd1, 5'd9, 12'd2, 32'h200, 32'h1234_ABCD);
        serve(1'b0, 3, 0, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0);

        // misaligned LW is dropped with a one-cycle pulse
        send_op(1'b1, 1'b0, 1'b0, 2'd2, 5'd4, 12'd0, 32'h103, 32'h0);
        check("misalign_pulse", 64'(misalign), 64'd1);
        check("misalign_no_req", 64'(mem_req), 64'd0);
        check("misalign_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("misalign_clear", 64'(misalign), 64'd0);
        check("misalign_no_req2", 64'(mem_req), 64'd0);

        // LHU at minimum latency: wb_valid visible in cycle 3
        send_op(1'b1, 1'b1, 1'b0, 2'd1, 5'd12, 12'd2, 32'h10, 32'h0);
        exp_q.push_back({5'd12, 32'h0000_F00D});
        serve(1'b1, 0, 0, 32'h10, 4'b1100, 32'h0, 32'hF00D_1234);
        check("lhu_wb_valid", 64'(wb_valid), 64'd1);
        check("lhu_wb_data", 64'(wb_data), 64'h0000_F00D);
        @(negedge clk);
        check("lhu_wb_pulse", 64'(wb_valid), 64'd0);

        // rvalid while idle is ignored
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("idle_rvalid_wb", 64'(wb_valid), 64'd0);

        // reset while waiting for the load response; late rvalid ignored
        send_op(1'b1, 1'b0, 1'b0, 2'd2, 5'd3, 12'd0, 32'h40, 32'h0);
        check("lw_req", 64'(mem_req), 64'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("lw_wait", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(in_ready), 64'd1);
        check("midrst_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late_rvalid_wb", 64'(wb_valid), 64'd0);
        check("late_rvalid_ready", 64'(in_ready), 64'd1);

        // nop back-to-back with LW to x0
        send_op(1'b1, 1'b0, 1'b1, 2'd2, 5'd5, 12'd0, 32'h81, 32'h0);
        check("nop_no_req", 64'(mem_req), 64'd0);
        check("nop_no_misalign", 64'(misalign), 64'd0);
        send_op(1'b1, 1'b0, 1'b0, 2'd2, 5'd0, 12'd0, 32'h80, 32'h0);
        serve(1'b1, 1, 1, 32'h80, 4'b1111, 32'h0, 32'h5555_AAAA);
        repeat (2) begin
            check("x0_no_wb", 64'(wb_valid), 64'd0);
            @(negedge clk);
        end

        // random aligned traffic
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  sz;
            logic        ld, zx;
            logic [4:0]  r;
            logic [11:0] im;
            logic [31:0] base, ea, d, rdat;
            sz   = 2'($urandom_range(0, 3));
            ld   = 1'($urandom_range(0, 1));
            zx   = 1'($urandom_range(0, 1));
            r    = 5'($urandom_range(0, 31));
            im   = 12'($urandom) & 12'hFFC;
            base = $urandom & 32'hFFFF_FFFC;
            if (sz == 2'd0) base = base | 32'($urandom_range(0, 3));
            if (sz == 2'd1) base = base | 32'($urandom_range(0, 1) * 2);
            d    = $urandom;
            rdat = $urandom;
            ea   = base + {{20{im[11]}}, im};
            send_op(ld, zx, 1'b0, sz, r, im, base, d);
            if (ld && r != 5'd0) exp_q.push_back({r, f_load(sz, zx, ea, rdat)});
            serve(ld, $urandom_range(0, 3), $urandom_range(0, 2),
                  {ea[31:2], 2'b00}, f_be(sz, ea), f_wdata(sz, d), rdat);
        end
        repeat (2) @(negedge clk);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
